// File: rtl/xslide_ctrl.sv
// xslide_ctrl: sequencing controller in front of a slide-window accumulator.
// It flushes the accumulator on start, streams samples into it, suppresses
// results until the window holds NWINDOWS real samples, then forwards
// decimated window sums. It also handles stop/drain, restart and stream gaps.
module xslide_ctrl #(
  parameter int BWID     = 16,
  parameter int NWINDOWS = 64,
  parameter int DECW     = 8,
  localparam int OWID    = BWID + $clog2(NWINDOWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_stop,
  input  logic [DECW-1:0] cfg_dec,
  input  logic [BWID-1:0] s_din,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            acc_rst,
  output logic [BWID-1:0] acc_din,
  output logic            acc_nd,
  input  logic [OWID-1:0] acc_dout,
  input  logic            acc_dv,
  output logic [OWID-1:0] m_dout,
  output logic            m_valid,
  output logic            busy,
  output logic            fill_done,
  output logic            err
);

  // Fill counter only has to reach NWINDOWS-1; the accept at that value ends FILL.
  localparam int FCW = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1;
  // Tag FIFO sized with headroom over the accumulator's in-flight sample count.
  localparam int TAG_DEPTH = 8;
  localparam int TPW = 3;
  localparam int TCW = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    FILL  = 3'd2,
    RUN   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t state_reg;

  logic                 flush_cnt_reg;
  logic [FCW-1:0]       fill_cnt_reg;
  logic [DECW-1:0]      dec_reg;
  logic [DECW-1:0]      dec_cnt_reg;

  logic [TAG_DEPTH-1:0] tag_mem_reg;
  logic [TPW-1:0]       wr_ptr_reg;
  logic [TPW-1:0]       rd_ptr_reg;
  logic [TCW-1:0]       tag_cnt_reg;

  logic                 s_ready_reg;
  logic                 acc_rst_reg;
  logic [BWID-1:0]      acc_din_reg;
  logic                 acc_nd_reg;
  logic [OWID-1:0]      m_dout_reg;
  logic                 m_valid_reg;
  logic                 busy_reg;
  logic                 fill_done_reg;
  logic                 err_reg;

  logic accept;
  logic streaming;
  logic start_take;
  logic stop_take;
  logic push;
  logic pop;
  logic dv_live;
  logic tag_empty;
  logic last_fill;
  logic eligible;
  logic keep;
  logic head_keep;

  assign streaming = (state_reg == FILL) || (state_reg == RUN);
  assign accept    = s_valid && s_ready_reg;

  // Stop beats start while streaming; start always wins from IDLE and STOP.
  assign stop_take  = cfg_stop && streaming;
  assign start_take = cfg_start &&
                      ((state_reg == IDLE) || (state_reg == STOP) ||
                       (streaming && !cfg_stop));

  // A sample handshaked on the restart edge is consumed but dropped: the
  // accumulator is about to be flushed, so forwarding it would be stale.
  assign push = accept && !start_take;

  assign tag_empty = (tag_cnt_reg == '0);
  assign last_fill = (fill_cnt_reg == FCW'(NWINDOWS - 1));
  assign eligible  = (state_reg == RUN) || ((state_reg == FILL) && last_fill);
  assign keep      = eligible && (dec_cnt_reg == '0);
  assign head_keep = tag_mem_reg[rd_ptr_reg];

  // acc_dv arriving while the accumulator is held in reset belongs to the
  // abandoned stream; it neither pops tags nor counts as an orphan result.
  assign dv_live = acc_dv && (state_reg != FLUSH);
  assign pop     = dv_live && !tag_empty;

  // Main sequencer: state, handshake/strobe outputs and result forwarding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= 1'b0;
      dec_reg       <= DECW'(1);
      s_ready_reg   <= 1'b0;
      acc_rst_reg   <= 1'b0;
      acc_din_reg   <= '0;
      acc_nd_reg    <= 1'b0;
      m_dout_reg    <= '0;
      m_valid_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      fill_done_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      acc_nd_reg  <= push;
      if (push) begin
        acc_din_reg <= s_din;
      end

      m_valid_reg <= 1'b0;
      if (pop && head_keep && !start_take) begin
        m_valid_reg <= 1'b1;
        m_dout_reg  <= acc_dout;
      end

      if (start_take) begin
        err_reg <= 1'b0;
      end else if (dv_live && tag_empty) begin
        err_reg <= 1'b1;
      end

      if (start_take) begin
        state_reg     <= FLUSH;
        flush_cnt_reg <= 1'b0;
        dec_reg       <= (cfg_dec == '0) ? DECW'(1) : cfg_dec;
        acc_rst_reg   <= 1'b1;
        s_ready_reg   <= 1'b0;
        busy_reg      <= 1'b1;
        fill_done_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            busy_reg <= 1'b0;
          end
          FLUSH: begin
            if (flush_cnt_reg) begin
              state_reg   <= FILL;
              acc_rst_reg <= 1'b0;
              s_ready_reg <= 1'b1;
            end else begin
              flush_cnt_reg <= 1'b1;
            end
          end
          FILL: begin
            if (stop_take) begin
              state_reg   <= STOP;
              s_ready_reg <= 1'b0;
            end else if (accept && last_fill) begin
              state_reg     <= RUN;
              fill_done_reg <= 1'b1;
            end
          end
          RUN: begin
            if (stop_take) begin
              state_reg     <= STOP;
              s_ready_reg   <= 1'b0;
              fill_done_reg <= 1'b0;
            end
          end
          STOP: begin
            if (tag_empty && !acc_nd_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg     <= IDLE;
            s_ready_reg   <= 1'b0;
            acc_rst_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            fill_done_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // Fill and decimation counters; both restart from zero on every flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_cnt_reg <= '0;
      dec_cnt_reg  <= '0;
    end else if (start_take || (state_reg == FLUSH)) begin
      fill_cnt_reg <= '0;
      dec_cnt_reg  <= '0;
    end else begin
      if (push && (state_reg == FILL) && !last_fill) begin
        fill_cnt_reg <= fill_cnt_reg + FCW'(1);
      end
      if (push && eligible) begin
        dec_cnt_reg <= (dec_cnt_reg == dec_reg - DECW'(1)) ? '0 : dec_cnt_reg + DECW'(1);
      end
    end
  end

  // Tag FIFO pointers: one entry per accumulator strobe, retired per acc_dv.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      tag_cnt_reg <= '0;
    end else if (start_take || (state_reg == FLUSH)) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      tag_cnt_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_reg + TPW'(push);
      rd_ptr_reg  <= rd_ptr_reg + TPW'(pop);
      tag_cnt_reg <= tag_cnt_reg + TCW'(push) - TCW'(pop);
    end
  end

  // Tag FIFO storage: each entry holds the keep bit of one in-flight sample.
  for (genvar gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
    // Entry gi captures the keep bit when the write pointer lands on it.
    always_ff @(posedge clk) begin
      if (!rst) begin
        tag_mem_reg[gi] <= 1'b0;
      end else if (push && (wr_ptr_reg == TPW'(gi))) begin
        tag_mem_reg[gi] <= keep;
      end
    end
  end

  // The accumulator is held in reset for as long as the controller is.
  assign acc_rst   = acc_rst_reg | ~rst;
  assign s_ready   = s_ready_reg;
  assign acc_din   = acc_din_reg;
  assign acc_nd    = acc_nd_reg;
  assign m_dout    = m_dout_reg;
  assign m_valid   = m_valid_reg;
  assign busy      = busy_reg;
  assign fill_done = fill_done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_xslide_ctrl.sv
// Testbench for xslide_ctrl with a behavioural slide-window accumulator
// and a scoreboard of expected window sums.
module tb_xslide_ctrl;

  localparam int BWID = 8;
  localparam int NWIN = 4;
  localparam int DECW = 4;
  localparam int OWID = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_stop = 1'b0;
  logic [DECW-1:0] cfg_dec = '0;
  logic [BWID-1:0] s_din = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            acc_rst;
  logic [BWID-1:0] acc_din;
  logic            acc_nd;
  logic [OWID-1:0] acc_dout;
  logic            acc_dv;
  logic [OWID-1:0] m_dout;
  logic            m_valid;
  logic            busy;
  logic            fill_done;
  logic            err;

  int n_assert = 0;
  int n_fail = 0;
  int n_mv = 0;
  int cyc = 0;
  int first_mv_cyc = -1;
  int last_acc_cyc = 0;

  always #5 clk = ~clk;

  xslide_ctrl #(.BWID(BWID), .NWINDOWS(NWIN), .DECW(DECW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_dec(cfg_dec), .s_din(s_din), .s_valid(s_valid), .s_ready(s_ready),
    .acc_rst(acc_rst), .acc_din(acc_din), .acc_nd(acc_nd),
    .acc_dout(acc_dout), .acc_dv(acc_dv), .m_dout(m_dout), .m_valid(m_valid),
    .busy(busy), .fill_done(fill_done), .err(err)
  );

  // Accumulator model: registered input, then two stages (strobe after e0 -> acc_dv seen at e4)
  logic                   nd1, dv2, mdl_dv, force_dv = 1'b0;
  logic [BWID-1:0]        din1;
  logic signed [OWID-1:0] win [3];
  logic signed [OWID-1:0] sum2, mdl_dout;

  always @(posedge clk) begin
    if (acc_rst) begin
      nd1 <= 1'b0; din1 <= '0; dv2 <= 1'b0; sum2 <= '0;
      mdl_dv <= 1'b0; mdl_dout <= '0;
      win[0] <= '0; win[1] <= '0; win[2] <= '0;
    end else begin
      nd1 <= acc_nd;
      din1 <= acc_din;
      dv2 <= nd1;
      if (nd1) begin
        win[0] <= {{2{din1[7]}}, din1};
        win[1] <= win[0];
        win[2] <= win[1];
        sum2 <= {{2{din1[7]}}, din1} + win[0] + win[1] + win[2];
      end
      mdl_dv <= dv2;
      mdl_dout <= sum2;
    end
  end

  assign acc_dv = mdl_dv | force_dv;
  assign acc_dout = mdl_dout;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [OWID-1:0] exp_q[$];
  int sb_dec, sb_fill, sb_dcnt;
  int sb_hist[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_start(input int d);
    sb_dec = (d == 0) ? 1 : d;
    sb_fill = 0;
    sb_dcnt = 0;
    for (int i = 0; i < 4; i++) sb_hist[i] = 0;
    exp_q.delete();
  endtask

  task automatic sb_accept(input logic [7:0] d);
    int s;
    for (int i = 3; i > 0; i--) sb_hist[i] = sb_hist[i-1];
    sb_hist[0] = int'($signed(d));
    if (sb_fill < NWIN) sb_fill++;
    if (sb_fill == NWIN) begin
      s = sb_hist[0] + sb_hist[1] + sb_hist[2] + sb_hist[3];
      if (sb_dcnt == 0) exp_q.push_back(OWID'(s));
      sb_dcnt = (sb_dcnt + 1) % sb_dec;
    end
  endtask

  // Output monitor: every m_valid pulse must match the next expected sum
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      n_mv++;
      if (first_mv_cyc < 0) first_mv_cyc = cyc;
      if (exp_q.size() == 0) chk("m_valid_unexpected", m_valid, 0);
      else chk("m_dout", m_dout, exp_q.pop_front());
      $display("out  cyc=%0d m_dout=%0h", cyc, m_dout);
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic send(input logic [7:0] d);
    bit r;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_din = d;
    do begin
      r = s_ready;
      @(negedge clk);
      n++;
    end while (!r && n < 50);
    s_valid = 1'b0;
    chk("s_accept", r, 1);
    if (r) begin
      sb_accept(d);
      last_acc_cyc = cyc;
      chk("acc_nd", acc_nd, 1);
      chk("acc_din", acc_din, d);
      $display("in   cyc=%0d s_din=%0h", cyc, d);
    end
  endtask

  task automatic start(input logic [3:0] d, input bit with_stop);
    int nr;
    cfg_start = 1'b1;
    cfg_stop = with_stop;
    cfg_dec = d;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    sb_start(d);
    chk("busy_after_start", busy, 1);
    nr = int'(acc_rst);
    @(negedge clk);
    nr += int'(acc_rst);
    @(negedge clk);
    nr += int'(acc_rst);
    chk("acc_rst_cycles", nr, 2);
    chk("s_ready_in_fill", s_ready, 1);
    chk("err_after_start", err, 0);
    $display("start cyc=%0d dec=%0d", cyc, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc_rst", acc_rst, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_acc_nd", acc_nd, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_acc_rst", acc_rst, 0);
    // Stop in IDLE is ignored
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    chk("idle_stop_ignored", busy, 0);

    // Test 1: dec=1, 1..10 back-to-back; start+stop together from IDLE -> start wins
    start(4'd1, 1'b1);
    base = n_mv;
    first_mv_cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      send(8'(i));
      if (i == 3) chk("fill_done_before", fill_done, 0);
      if (i == 4) begin
        base = n_mv;
        n = cyc;
        chk("fill_done_after", fill_done, 1);
      end
    end
    drain();
    chk("t1_pulses", n_mv - base, 7);
    chk("t1_latency", first_mv_cyc - n, 4);

    // Test 2: dec=3 with s_valid gaps
    start(4'd3, 1'b0);
    base = n_mv;
    for (int i = 1; i <= 10; i++) begin
      send(8'(i));
      @(negedge clk);
    end
    drain();
    chk("t2_pulses", n_mv - base, 3);

    // Test 3: dec=0 acts as 1, negative sums
    start(4'd0, 1'b0);
    base = n_mv;
    repeat (4) send(8'hFF);
    send(8'h01);
    drain();
    chk("t3_pulses", n_mv - base, 2);

    // Test 4: stop one cycle after the 6th accept
    start(4'd1, 1'b0);
    base = n_mv;
    for (int i = 1; i <= 6; i++) send(8'(i));
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    chk("stop_s_ready", s_ready, 0);
    chk("stop_busy_held", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("stop_busy_drop", busy, 0);
    chk("stop_queue_empty", exp_q.size(), 0);
    chk("t4_pulses", n_mv - base, 3);

    // Test 5: restart in RUN after sample 6, then 100 x4
    start(4'd1, 1'b0);
    base = n_mv;
    for (int i = 1; i <= 6; i++) send(8'(i));
    start(4'd1, 1'b0);
    repeat (4) send(8'd100);
    drain();
    chk("t5_pulses", n_mv - base, 1);

    // Test 6: reset mid-RUN, then orphan acc_dv sets err
    start(4'd1, 1'b0);
    for (int i = 1; i <= 6; i++) send(8'(i));
    rst = 1'b0;
    #1;
    chk("midrst_acc_rst_comb", acc_rst, 1);
    @(negedge clk);
    exp_q.delete();
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fill_done", fill_done, 0);
    chk("midrst_acc_nd", acc_nd, 0);
    chk("midrst_acc_din", acc_din, 0);
    chk("midrst_m_dout", m_dout, 0);
    rst = 1'b1;
    base = n_mv;
    repeat (20) @(negedge clk);
    chk("midrst_no_output", n_mv - base, 0);
    force_dv = 1'b1;
    @(negedge clk);
    force_dv = 1'b0;
    chk("err_set", err, 1);
    repeat (2) @(negedge clk);
    chk("err_sticky", err, 1);
    chk("err_no_m_valid", n_mv - base, 0);
    start(4'd1, 1'b0);
    base = n_mv;
    repeat (4) send(8'd5);
    drain();
    chk("t6_pulses", n_mv - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xslide_ctrl.md
Name: xslide_ctrl

Overview:
- Sequencing controller placed in front of the slide-window accumulator (fixed NWINDOWS window, 2-clk latency, active-high rst, iND/iDin in, oDout/oDV out).
- On a start command it flushes the accumulator, then streams samples into it. Results are suppressed until the window holds NWINDOWS real samples.
- After that it forwards results, decimated by a runtime factor, and handles stop/restart and stream gaps.
- It sits between an upstream valid/ready sample source and the downstream consumer of window sums.

Parameters:
- BWID, 16, sample width (signed two's complement).
- NWINDOWS, 64, accumulator window length; must match the accumulator instance; power of two, ≥2.
- DECW, 8, width of the decimation factor.
- OWID (localparam), BWID+clog2(NWINDOWS), result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- cfg_start  in  1  single-cycle start/restart pulse.
- cfg_stop  in  1  single-cycle stop pulse.
- cfg_dec  in  DECW  decimation factor, sampled on accepted start; 0 treated as 1.
- s_din  in  BWID  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  controller accepts a sample this cycle.
- acc_rst  out  1  active-high reset to accumulator.
- acc_din  out  BWID  accumulator data.
- acc_nd  out  1  accumulator new-data strobe.
- acc_dout  in  OWID  accumulator sum.
- acc_dv  in  1  accumulator output valid.
- m_dout  out  OWID  forwarded window sum.
- m_valid  out  1  m_dout valid, single-cycle, no backpressure.
- busy  out  1  state != IDLE.
- fill_done  out  1  high in RUN.
- err  out  1  sticky: acc_dv seen with empty tag pipeline; cleared by reset or accepted start.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE.
  - All outputs 0, except acc_rst, which is 1 while rst=0.
  - Counters and tag pipeline cleared.
- States: IDLE, FLUSH, FILL, RUN, STOP.
- IDLE:
  - s_ready=0, acc_nd=0.
  - cfg_start → FLUSH; latch dec=max(cfg_dec,1); clear err.
  - cfg_stop ignored.
- FLUSH:
  - acc_rst=1 for exactly 2 cycles, then FILL.
  - fill_cnt=0, dec_cnt=0, tag pipeline cleared.
  - s_ready=0.
- FILL and RUN:
  - s_ready=1.
  - Accept when s_valid&s_ready. The next cycle has acc_nd=1 and acc_din=s_din (registered); otherwise acc_nd=0 and acc_din holds.
  - Gaps in s_valid are legal and do not affect the result.
- FILL counting:
  - fill_cnt increments per accepted sample.
  - The accept that makes the count NWINDOWS transitions to RUN.
  - That sample is the first "eligible" sample; earlier samples are tagged keep=0.
- Eligible samples:
  - keep=(dec_cnt==0).
  - dec_cnt increments per eligible sample and wraps from dec-1 to 0.
- Tag pipeline:
  - A keep bit is pushed with each acc_nd.
  - It pops on acc_dv (2 clk later; depth ≥3 to cover back-to-back samples).
  - On acc_dv with keep=1, the next cycle has m_valid=1 and m_dout=acc_dout.
- Latency: sample accepted at edge e0 → m_valid high after edge e4.
- Stop:
  - cfg_stop in FILL or RUN → STOP: s_ready=0 immediately (same cycle as the command is registered).
  - STOP remains until the tag pipeline is empty and no acc_nd is pending.
  - In-flight kept results are still delivered. Then → IDLE.
- Restart:
  - cfg_start in FILL, RUN or STOP → FLUSH; in-flight results are discarded (tags cleared).
  - cfg_start in FLUSH is ignored.
  - cfg_start and cfg_stop in the same cycle: stop wins in FILL/RUN; start wins in IDLE.
- Arithmetic: the controller performs no arithmetic on data; m_dout is acc_dout bit-exact (signed OWID).
- err sets when acc_dv=1 and the tag pipeline is empty. No other effect.

Test Plan (bench: BWID=8, NWINDOWS=4, DECW=4):
- Start with cfg_dec=1, stream samples 1..10 back-to-back → exactly 7 m_valid pulses with m_dout=10,14,18,22,26,30,34. First pulse 4 clk after the 4th sample is accepted; fill_done rises on the cycle after the 4th accept.
- cfg_dec=3, samples 1..10 with s_valid toggling 1/0 → m_dout=10,22,34 only; values unaffected by gaps.
- Samples 8'hFF ×4, cfg_dec=0 → single output m_dout=10'h3FC (−4); decimation behaves as 1.
- Stop pulse one cycle after the 6th accept → results for samples 4,5,6 (10,14,18) still delivered. s_ready=0 from the stop; busy drops to 0 after the pipeline drains.
- Start pulse in RUN after sample 6, then samples 100,100,100,100 → acc_rst high 2 cycles; no stale outputs; first output 400.
- rst=0 for 1 cycle mid-RUN → all outputs 0, state IDLE, no m_valid afterwards until a new start. Force acc_dv with no samples → err=1, cleared by next start.
